i2s_slave_tx: RTL and testbench

I2S_SLAVE_TX -- requirements
Module: i2s_slave_tx

---
 rtl/i2s_slave_tx.sv | 166 ++++++++++++++++
 tb/tb_i2s_slave_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_tx.sv
// I2S slave transmitter: buffers one left/right pair from an AXI-Stream input and
// serializes it onto sdout, timed by an externally supplied sclk/lrck.
module i2s_slave_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    input  logic                  sclk,
    input  logic                  lrck,
    output logic                  sdout,
    output logic                  underrun,
    output logic                  sync_err
);

    localparam int PAD_WIDTH = SLOT_WIDTH - DATA_WIDTH;

    typedef enum logic [1:0] {
        EXP_L,
        EXP_R,
        FULL
    } state_t;

    logic                  sclk_s1_q, sclk_s2_q, sclk_d1_q;
    logic                  lrck_s1_q, lrck_s2_q;
    logic                  lrck_ref_q, lrck_ref_d;
    logic                  ref_valid_q, ref_valid_d;
    logic                  started_q, started_d;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] left_buf_q, left_buf_d;
    logic [DATA_WIDTH-1:0] right_buf_q, right_buf_d;
    logic [DATA_WIDTH-1:0] act_l_q, act_l_d;
    logic [DATA_WIDTH-1:0] act_r_q, act_r_d;
    logic [SLOT_WIDTH-1:0] shift_q, shift_d;
    logic                  sdout_q, sdout_d;
    logic                  underrun_q, underrun_d;
    logic                  sync_err_q, sync_err_d;

    logic fe, chan_change, frame_start, ready, beat;

    // sclk_d1_q holds the previous synchronized sclk so a 1->0 step marks a falling edge.
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_d1_q <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_d1_q <= sclk_s2_q;
            lrck_s1_q <= lrck;
            lrck_s2_q <= lrck_s1_q;
        end
    end

    always_comb begin
        fe          = sclk_d1_q & ~sclk_s2_q;
        chan_change = fe & ref_valid_q & (lrck_s2_q != lrck_ref_q);
        frame_start = chan_change & ~lrck_s2_q;
        ready       = started_q & (state_q != FULL) & ~frame_start;
        beat        = s_axis_valid & ready;

        lrck_ref_d  = lrck_ref_q;
        ref_valid_d = ref_valid_q;
        started_d   = 1'b1;
        state_d     = state_q;
        left_buf_d  = left_buf_q;
        right_buf_d = right_buf_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        shift_d     = shift_q;
        sdout_d     = sdout_q;
        underrun_d  = 1'b0;
        sync_err_d  = 1'b0;

        if (fe) begin
            lrck_ref_d  = lrck_s2_q;
            ref_valid_d = 1'b1;
        end

        // Without a full pair the held left sample survives so the stream can still complete it.
        if (frame_start) begin
            if (state_q == FULL) begin
                act_l_d = left_buf_q;
                act_r_d = right_buf_q;
                state_d = EXP_L;
            end else begin
                act_l_d    = '0;
                act_r_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (beat) begin
            case (state_q)
                EXP_L: begin
                    if (!s_axis_last) begin
                        left_buf_d = s_axis_data;
                        state_d    = EXP_R;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                EXP_R: begin
                    if (s_axis_last) begin
                        right_buf_d = s_axis_data;
                        state_d     = FULL;
                    end else begin
                        left_buf_d = s_axis_data;
                        sync_err_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // The change edge itself carries the I2S one-bit delay slot; the MSB follows on the next fe.
        if (chan_change) begin
            shift_d = {(lrck_s2_q ? act_r_q : act_l_d), {PAD_WIDTH{1'b0}}};
            sdout_d = 1'b0;
        end else if (fe) begin
            sdout_d = shift_q[SLOT_WIDTH-1];
            shift_d = {shift_q[SLOT_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            lrck_ref_q  <= 1'b0;
            ref_valid_q <= 1'b0;
            started_q   <= 1'b0;
            state_q     <= EXP_L;
            left_buf_q  <= '0;
            right_buf_q <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            shift_q     <= '0;
            sdout_q     <= 1'b0;
            underrun_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            lrck_ref_q  <= lrck_ref_d;
            ref_valid_q <= ref_valid_d;
            started_q   <= started_d;
            state_q     <= state_d;
            left_buf_q  <= left_buf_d;
            right_buf_q <= right_buf_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            shift_q     <= shift_d;
            sdout_q     <= sdout_d;
            underrun_q  <= underrun_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign s_axis_ready = ready;
    assign sdout        = sdout_q;
    assign underrun     = underrun_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_i2s_slave_tx.sv
// Bench for i2s_slave_tx: plays an I2S master (sclk = axis_clk/8, lrck = sclk/64),
// feeds AXIS beats and compares every cycle against a bit-index based reference model.
module tb_i2s_slave_tx;

   localparam int DW = 24;
   localparam int SW = 32;

   logic          axis_clk = 1'b0;
   logic          axis_resetn;
   logic [DW-1:0] s_axis_data;
   logic          s_axis_valid;
   logic          s_axis_ready;
   logic          s_axis_last;
   logic          sclk;
   logic          lrck;
   logic          sdout;
   logic          underrun;
   logic          sync_err;

   i2s_slave_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
      .axis_clk    (axis_clk),
      .axis_resetn (axis_resetn),
      .s_axis_data (s_axis_data),
      .s_axis_valid(s_axis_valid),
      .s_axis_ready(s_axis_ready),
      .s_axis_last (s_axis_last),
      .sclk        (sclk),
      .lrck        (lrck),
      .sdout       (sdout),
      .underrun    (underrun),
      .sync_err    (sync_err)
   );

   always #5 axis_clk = ~axis_clk;

   int checks = 0;
   int failures = 0;

   // Master clock generator state: phase within the 8-cycle sclk period and count of falls.
   int ph;
   int nfall;

   // Reference model: pair buffer as flags, active words, and position within the current slot.
   bit            m_started, m_have_left, m_full, m_ref_valid, m_lr_ref;
   logic [DW-1:0] m_left, m_pair_l, m_pair_r, m_act_l, m_act_r, m_word;
   int            m_idx;
   bit            m_sdout, m_underrun, m_syncerr;
   int            m_frames;
   bit            f1, f2, lr1, lr2;

   logic [DW:0]   beat_q[$];
   bit            rst_req, rel_req;
   int            underrun_seen, syncerr_seen;

   // One comparison: counts it and reports the observed/expected pair on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_started   = 1'b0;
      m_have_left = 1'b0;
      m_full      = 1'b0;
      m_ref_valid = 1'b0;
      m_lr_ref    = 1'b0;
      m_left      = '0;
      m_pair_l    = '0;
      m_pair_r    = '0;
      m_act_l     = '0;
      m_act_r     = '0;
      m_word      = '0;
      m_idx       = 0;
      m_sdout     = 1'b0;
      m_underrun  = 1'b0;
      m_syncerr   = 1'b0;
      f1 = 1'b0; f2 = 1'b0; lr1 = 1'b0; lr2 = 1'b0;
   endtask

   // One axis_clk cycle: drive pins on the falling edge, check outputs, then advance the
   // model across the next rising edge. A pin fall is seen by the block 3 rising edges later.
   task automatic applyStimulus();
      bit fell_now, fe, lr, change, fstart, rdy, acc;
      @(negedge axis_clk);
      fell_now = 1'b0;
      ph = (ph + 1) % 8;
      if (ph == 0) sclk = 1'b1;
      if (ph == 4) begin
         sclk = 1'b0;
         fell_now = 1'b1;
         nfall++;
         if (nfall % 32 == 0) lrck = ~lrck;
      end
      if (rst_req) begin
         axis_resetn = 1'b0;
         rst_req = 1'b0;
      end
      if (rel_req && ph == 0) begin
         axis_resetn = 1'b1;
         rel_req = 1'b0;
      end
      if (beat_q.size() > 0) begin
         s_axis_valid = 1'b1;
         {s_axis_last, s_axis_data} = beat_q[0];
      end else begin
         s_axis_valid = 1'b0;
         s_axis_last  = 1'b0;
         s_axis_data  = '0;
      end
      #1;
      if (!axis_resetn) modelReset();

      fe     = f2;
      lr     = lr2;
      change = fe && m_ref_valid && (lr != m_lr_ref);
      fstart = change && !lr;
      rdy    = axis_resetn && m_started && !m_full && !fstart;

      checkOutput("sdout", {31'b0, sdout}, {31'b0, m_sdout});
      checkOutput("underrun", {31'b0, underrun}, {31'b0, m_underrun});
      checkOutput("sync_err", {31'b0, sync_err}, {31'b0, m_syncerr});
      checkOutput("ready", {31'b0, s_axis_ready}, {31'b0, rdy});
      if (underrun) underrun_seen++;
      if (sync_err) syncerr_seen++;

      if (axis_resetn) begin
         acc = s_axis_valid && rdy;
         m_underrun = 1'b0;
         m_syncerr  = 1'b0;
         if (fe) begin
            m_ref_valid = 1'b1;
            m_lr_ref    = lr;
         end
         if (fstart) begin
            m_frames++;
            if (m_full) begin
               m_act_l = m_pair_l;
               m_act_r = m_pair_r;
               m_full  = 1'b0;
               m_have_left = 1'b0;
            end else begin
               m_act_l = '0;
               m_act_r = '0;
               m_underrun = 1'b1;
            end
         end else if (acc) begin
            if (!m_have_left) begin
               if (!s_axis_last) begin
                  m_left = s_axis_data;
                  m_have_left = 1'b1;
               end else m_syncerr = 1'b1;
            end else if (s_axis_last) begin
               m_pair_l = m_left;
               m_pair_r = s_axis_data;
               m_full = 1'b1;
               m_have_left = 1'b0;
            end else begin
               m_left = s_axis_data;
               m_syncerr = 1'b1;
            end
            void'(beat_q.pop_front());
         end
         if (change) begin
            m_word  = lr ? m_act_r : m_act_l;
            m_idx   = 0;
            m_sdout = 1'b0;
         end else if (fe) begin
            m_idx++;
            m_sdout = (m_idx >= 1 && m_idx <= DW) ? m_word[DW-m_idx] : 1'b0;
         end
         m_started = 1'b1;
         f2 = f1; lr2 = lr1;
         f1 = fell_now; lr1 = lrck;
      end
   endtask

   task automatic runFrames(input int n);
      int target, budget;
      target = m_frames + n;
      budget = n * 600 + 200;
      while (m_frames < target && budget > 0) begin
         applyStimulus();
         budget--;
      end
      if (m_frames < target) checkOutput("frame_timeout", m_frames, target);
      repeat (4) applyStimulus();
   endtask

   task automatic waitRelease();
      int budget;
      budget = 40;
      while (rel_req && budget > 0) begin
         applyStimulus();
         budget--;
      end
      if (rel_req) checkOutput("release_timeout", 0, 1);
   endtask

   task automatic pushPair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      beat_q.push_back({1'b0, l});
      beat_q.push_back({1'b1, r});
   endtask

   initial begin
      int u0, s0, budget;
      bit exp_last, l;
      logic [DW-1:0] d;

      ph = 0; nfall = 0; m_frames = 0;
      sclk = 1'b1; lrck = 1'b1;
      axis_resetn = 1'b0;
      s_axis_valid = 1'b0; s_axis_last = 1'b0; s_axis_data = '0;
      rst_req = 1'b0; rel_req = 1'b0;
      underrun_seen = 0; syncerr_seen = 0;
      modelReset();

      repeat (3) applyStimulus();
      rel_req = 1'b1;
      waitRelease();

      $display("[TB] idle frames with no data");
      u0 = underrun_seen;
      runFrames(3);
      checkOutput("idle_underrun_count", underrun_seen - u0, 3);

      $display("[TB] directed pair 800001/7FFFFE");
      u0 = underrun_seen;
      pushPair(24'h800001, 24'h7FFFFE);
      pushPair(24'h800001, 24'h7FFFFE);
      runFrames(2);
      checkOutput("pair_underrun_count", underrun_seen - u0, 0);

      $display("[TB] channel order error");
      s0 = syncerr_seen;
      beat_q.push_back({1'b1, 24'hABCDEF});
      beat_q.push_back({1'b0, 24'h123456});
      beat_q.push_back({1'b1, 24'h654321});
      runFrames(2);
      checkOutput("sync_err_count", syncerr_seen - s0, 1);

      $display("[TB] back-pressure while full");
      for (int i = 0; i < 3; i++) begin
         pushPair(DW'($urandom), DW'($urandom));
      end
      runFrames(4);
      checkOutput("backpressure_drained", beat_q.size(), 0);

      $display("[TB] reset in the middle of the left slot");
      pushPair(DW'($urandom), DW'($urandom));
      runFrames(1);
      budget = 600;
      while (!(lrck == 1'b0 && nfall % 32 == 16 && ph == 4) && budget > 0) begin
         applyStimulus();
         budget--;
      end
      if (budget == 0) checkOutput("midslot_timeout", 0, 1);
      rst_req = 1'b1;
      repeat (10) applyStimulus();
      rel_req = 1'b1;
      waitRelease();
      pushPair(24'hC0FFEE, 24'h0BEEF1);
      runFrames(3);

      $display("[TB] randomized beats");
      exp_last = 1'b0;
      repeat (4000) begin
         if (beat_q.size() == 0 && ($urandom % 16) == 0) begin
            l = exp_last;
            if (($urandom % 8) == 0) l = ~l;
            d = DW'($urandom);
            beat_q.push_back({l, d});
            exp_last = ~l;
         end
         applyStimulus();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
